// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation, handshaked imem requests,
// and an in-order DEPTH-entry queue of returned words with redirect flush.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head, tail, fill_idx;
  logic [CW-1:0]    alloc_cnt, fill_cnt, drop_cnt, unfilled;
  logic [CW:0]      credit;
  logic [DEPTH-1:0] filled;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      fetch_pc;
  logic             run;
  logic             grant, pop, outstanding, rsp_taken, drop_rsp, fill;
  logic             unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Dropped responses still occupy credit, so outstanding requests never exceed DEPTH.
  assign credit      = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign unfilled    = alloc_cnt - fill_cnt;
  assign imem_req    = run && !redirect && (credit < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;

  assign instr_valid = filled[head] && !redirect;
  assign pop         = instr_valid && instr_ready;
  assign instr       = filled[head] ? data_q[head]         : 32'h0;
  assign instr_pc    = filled[head] ? pc_q[head]           : 32'h0;
  assign instr_pc4   = filled[head] ? pc_q[head] + 32'd4   : 32'h0;

  // Responses are in order: stale ones (drop_cnt) drain before any new slot fills.
  assign outstanding = (unfilled != '0) || (drop_cnt != '0);
  assign rsp_taken   = imem_rvalid && outstanding;
  assign drop_rsp    = imem_rvalid && (drop_cnt != '0);
  assign fill        = imem_rvalid && (drop_cnt == '0) && (unfilled != '0);
  assign fill_idx    = PW'(head + fill_cnt[PW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      fetch_pc  <= RESET_PC;
      head      <= '0;
      tail      <= '0;
      alloc_cnt <= '0;
      fill_cnt  <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        head      <= '0;
        tail      <= '0;
        alloc_cnt <= '0;
        fill_cnt  <= '0;
        filled    <= '0;
        fetch_pc  <= {redirect_pc[31:2], 2'b00};
        drop_cnt  <= drop_cnt + unfilled - CW'(rsp_taken);
      end else begin
        if (grant) begin
          tail         <= PW'(tail + PW'(1));
          fetch_pc     <= fetch_pc + 32'd4;
          filled[tail] <= 1'b0;
        end
        if (fill) filled[fill_idx] <= 1'b1;
        if (pop) begin
          head         <= PW'(head + PW'(1));
          filled[head] <= 1'b0;
        end
        alloc_cnt <= alloc_cnt + CW'(grant) - CW'(pop);
        fill_cnt  <= fill_cnt + CW'(fill) - CW'(pop);
        drop_cnt  <= drop_cnt - CW'(drop_rsp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) pc_q[tail]       <= fetch_pc;
    if (fill)  data_q[fill_idx] <= imem_rdata;
  end

`ifndef SYNTHESIS
  rvalid_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> outstanding)
    else $error("imem_rvalid with no request outstanding");
`endif

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle execute datapath.
- Generates sequential PCs and issues requests to a handshaked instruction memory.
- Buffers returned words, with their PCs, in an in-order queue of DEPTH entries and presents them to the datapath through a valid/ready interface.
- Accepts branch/jump redirects from the datapath: flushes the queue and discards responses still in flight.

Parameters:
- DEPTH, 4, queue entries; power of two, range 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low (already decided).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; held stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted on this rising edge.
- imem_rvalid  in  1  response data valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect  in  1  one-cycle pulse: flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and forced to 0.
- instr_valid  out  1  head entry holds a returned instruction.
- instr  out  32  head instruction word.
- instr_pc  out  32  PC of the head instruction.
- instr_pc4  out  32  instr_pc + 4, modulo 2^32.
- instr_ready  in  1  consumer accepts head; a pop occurs when instr_valid && instr_ready.

Behaviour:
- Reset (rst_n=0):
  - fetch_pc = RESET_PC; all entries are empty.
  - alloc_cnt, fill_cnt and drop_cnt = 0.
  - imem_req = 0, instr_valid = 0, instr = 0, instr_pc = 0.
  - Reset mid-transaction abandons all in-flight requests. The memory is reset on the same rst_n, so no stale response follows.
- Entry lifecycle:
  - A slot is allocated at the grant edge: the tail slot records pc = fetch_pc, filled = 0, tail++, and fetch_pc += 4.
  - A slot is filled at the rvalid edge: the oldest allocated, unfilled slot stores imem_rdata and sets filled = 1.
  - A slot is freed at the pop edge: head++.
- Request issue:
  - imem_req = (alloc_cnt + drop_cnt < DEPTH) && !redirect.
  - drop_cnt counts toward credit, so at most DEPTH requests are ever outstanding.
- Output timing:
  - instr_valid = filled[head] && !redirect.
  - The outputs are driven from registers; instr, instr_pc and instr_pc4 read 0 when the queue is empty.
  - Minimum latency from grant to instr_valid is 2 cycles: response at +1, visible at +2.
  - Throughput is 1 instruction per cycle when the memory sustains it.
- Full queue: with alloc_cnt = DEPTH, imem_req = 0. A pop and a grant may occur on the same edge; credit is computed from pre-edge counts, so there is no bypass.
- Wrap-around:
  - Head and tail pointers wrap modulo DEPTH.
  - fetch_pc wraps from 32'hFFFF_FFFC to 0 with no error indication.
- Redirect (the edge on which redirect=1):
  - All entries are cleared; head = tail = 0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = (number of allocated, unfilled entries) − (1 if imem_rvalid on this edge).
  - No pop occurs this cycle, because instr_valid is forced to 0.
- Drop phase:
  - While drop_cnt > 0, each imem_rvalid decrements drop_cnt and its data is discarded.
  - New requests may issue during the drop phase, subject to the credit rule above.
  - Responses to new requests are routed into the queue only after drop_cnt reaches 0; ordering guarantees this.
- Redirect during the drop phase: drop_cnt accumulates, i.e. drop_cnt_next = drop_cnt + unfilled − rvalid.
- Protocol errors:
  - imem_rvalid with no outstanding request is ignored.
  - This condition is flagged by a simulation-only assertion.

Test Plan:
1. Zero-wait memory (gnt=1 always, rvalid 1 cycle after gnt), instr_ready=1, RESET_PC=0x100 -> first instr_valid 3 cycles after rst_n release with instr_pc=0x100, then 0x104, 0x108 on consecutive cycles; instr_pc4 = instr_pc + 4.
2. instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 grants, then imem_req=0. Raise instr_ready -> PCs 0x0, 0x4, 0x8, 0xC in order, then fetching resumes at 0x10 with no gap or duplicate.
3. Memory latency 3 cycles with 3 requests in flight, redirect to 0x2003 -> the next 3 rvalid words are discarded; the first instr_valid shows instr_pc=0x2000 carrying the data for 0x2000.
4. redirect on the same edge as imem_rvalid and a pending pop -> no pop, the rvalid word is dropped, drop_cnt = unfilled − 1, and the stream restarts at redirect_pc.
5. Two redirects 1 cycle apart with latency-4 memory -> only the second target's stream appears; no instruction from the first target or from the old stream is ever presented.
6. Start fetching at 0xFFFF_FFF8 via redirect, then assert rst_n=0 mid-stream -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. During the reset cycle instr_valid and imem_req drop to 0 immediately, and the restart is at RESET_PC.
